// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle-core multiply unit: word length,
// FSM state encoding and counter sizing.
package mcp_pkg;

  localparam int WL_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

  function automatic int cnt_width(input int wl);
    return $clog2(wl);
  endfunction

endpackage

// File: rtl/mcp_mult_acc.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the
// upper half (carry kept in bit 2*WL), then shift the whole accumulator right.
module mcp_mult_acc #(
  parameter int WL = 32
) (
  input  logic [2*WL:0]  acc,
  input  logic [WL-1:0]  mcand,
  output logic [2*WL:0]  acc_next
);

  logic [WL:0]   sum;
  logic [2*WL:0] added;

  always_comb begin
    sum      = {1'b0, acc[2*WL-1:WL]} + {1'b0, mcand};
    added    = acc[0] ? {sum, acc[WL-1:0]} : acc;
    acc_next = added >> 1;
  end

endmodule

// File: rtl/mcp_mult_unit.sv
// Iterative MULT/MULTU unit owning HI/LO. Optional macro
// MCP_MULT_EARLY_EXIT_EN finishes RUN as soon as no multiplier bits remain.
module mcp_mult_unit
  import mcp_pkg::*;
#(
  parameter int WL = WL_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          Start,
  input  logic          Signed_F,
  input  logic [WL-1:0] MultA,
  input  logic [WL-1:0] MultB,
  input  logic          HI_We,
  input  logic          LO_We,
  input  logic [WL-1:0] WrData,
  output logic [WL-1:0] HI,
  output logic [WL-1:0] LO,
  output logic          Busy,
  output logic          Done,
  output logic [1:0]    dbg_state
);

  localparam int CW = cnt_width(WL);

  // Handshake: Start is taken only in IDLE (valid with Signed_F/MultA/MultB);
  // Busy is the not-ready indication (RUN/FIX); Done pulses one cycle with
  // HI/LO already holding the product, and Busy is low in that cycle.
  mult_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WL:0] acc, acc_step, acc_run;
  logic [WL-1:0] mcand, a_mag, b_mag;
  logic [2*WL-1:0] prod;
  logic          sgn_neg;
  logic          early;

  assign a_mag = (Signed_F && MultA[WL-1]) ? -MultA : MultA;
  assign b_mag = (Signed_F && MultB[WL-1]) ? -MultB : MultB;
  assign prod  = sgn_neg ? -acc[2*WL-1:0] : acc[2*WL-1:0];
  assign dbg_state = state;

  mcp_mult_acc #(.WL(WL)) u_acc (
    .acc      (acc),
    .mcand    (mcand),
    .acc_next (acc_step)
  );

`ifdef MCP_MULT_EARLY_EXIT_EN
  logic [WL-1:0] rem_mask;

  // Remaining multiplier bits sit in acc[WL-1-cnt:0]; if none are set, the
  // rest of the iterations are pure shifts and can be done in one go.
  always_comb begin
    rem_mask = {WL{1'b1}} >> cnt;
    early    = (acc[WL-1:0] & rem_mask) == '0;
    acc_run  = early ? (acc >> (WL - int'(cnt))) : acc_step;
  end
`else
  always_comb begin
    early   = 1'b0;
    acc_run = acc_step;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (early || cnt == CW'(WL-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      cnt     <= '0;
      sgn_neg <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state <= state_nxt;
      Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            sgn_neg <= Signed_F & (MultA[WL-1] ^ MultB[WL-1]);
            mcand   <= a_mag;
            acc     <= {{(WL+1){1'b0}}, b_mag};
            cnt     <= '0;
            Busy    <= 1'b1;
          end else begin
            // Start wins over a same-cycle MTHI/MTLO.
            if (HI_We) HI <= WrData;
            if (LO_We) LO <= WrData;
          end
        end
        RUN: begin
          acc <= acc_run;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          HI   <= prod[2*WL-1:WL];
          LO   <= prod[WL-1:0];
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_mult_unit.sv
// Self-checking bench for mcp_mult_unit: directed corners, hazards, mid-run
// reset and randomized MULT/MULTU against an arithmetic reference.
module tb_mcp_mult_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Start, Signed_F, HI_We, LO_We;
  logic [31:0] MultA, MultB, WrData;
  logic [31:0] HI, LO;
  logic        Busy, Done;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [63:0] exp_q[$];

  mcp_mult_unit #(.WL(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Signed_F(Signed_F),
    .MultA(MultA), .MultB(MultB), .HI_We(HI_We), .LO_We(LO_We),
    .WrData(WrData), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic sf, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp;
    logic [63:0] ua, ub;
    if (sf) begin
      sa = a;
      sb = b;
      sp = longint'(sa) * longint'(sb);
      return sp;
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic int ref_latency(input logic sf, input logic [31:0] b);
`ifdef MCP_MULT_EARLY_EXIT_EN
    logic [31:0] mag;
    int c;
    mag = (sf && b[31]) ? -b : b;
    c = 0;
    while (c < 31 && (mag >> c) != 0) c++;
    return c + 2;
`else
    return (sf || b[0] || !b[0]) ? 33 : 33;
`endif
  endfunction

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic run_mult(input logic sf, input logic [31:0] a, input logic [31:0] b,
                          input int start_again_cyc, input int hi_we_cyc, input logic lo_we_same);
    logic [63:0] exp_p;
    int lat, exp_lat;
    bit done_seen;
    exp_q.push_back(ref_product(sf, a, b));
    exp_lat = ref_latency(sf, b);
    Start = 1'b1; Signed_F = sf; MultA = a; MultB = b;
    LO_We = lo_we_same; WrData = 32'h0BAD_0BAD;
    @(posedge CLK); #1;
    Start = 1'b0; LO_We = 1'b0;
    lat = 0;
    done_seen = 1'b0;
    while (!done_seen && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      Start = 1'b0; HI_We = 1'b0;
      if (Done) begin
        done_seen = 1'b1;
      end else begin
        check("busy_run", {63'b0, Busy}, 64'd1);
        check("hi_hold", {32'b0, HI}, {32'b0, model_hi});
        check("lo_hold", {32'b0, LO}, {32'b0, model_lo});
        if (lat == start_again_cyc) begin
          Start = 1'b1; Signed_F = 1'b0; MultA = 32'h1111_1111; MultB = 32'h2;
        end
        if (lat == hi_we_cyc) begin
          HI_We = 1'b1; WrData = 32'hDEAD_BEEF;
        end
      end
    end
    check("done_seen", {63'b0, done_seen}, 64'd1);
    if (done_seen) begin
      exp_p = exp_q.pop_front();
      check("latency", 64'(lat), 64'(exp_lat));
      check("product", {HI, LO}, exp_p);
      check("busy_done", {63'b0, Busy}, 64'd0);
      model_hi = exp_p[63:32];
      model_lo = exp_p[31:0];
    end else begin
      exp_q.delete();
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      check("done_pulse", {63'b0, Done}, 64'd0);
      check("busy_after", {63'b0, Busy}, 64'd0);
    end
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    HI_We = hw; LO_We = lw; WrData = d;
    @(posedge CLK); #1;
    HI_We = 1'b0; LO_We = 1'b0;
    if (hw) model_hi = d;
    if (lw) model_lo = d;
    check("mthi", {32'b0, HI}, {32'b0, model_hi});
    check("mtlo", {32'b0, LO}, {32'b0, model_lo});
  endtask

  task automatic reset_mid_run(input int at_cyc);
    Start = 1'b1; Signed_F = 1'b0; MultA = 32'd7; MultB = 32'd9;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int k = 0; k < at_cyc; k++) begin
      @(posedge CLK); #1;
    end
    RST_N = 1'b0;
    #1;
    check("rst_hi", {32'b0, HI}, 64'd0);
    check("rst_lo", {32'b0, LO}, 64'd0);
    check("rst_busy", {63'b0, Busy}, 64'd0);
    check("rst_done", {63'b0, Done}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  logic [31:0] corners [5];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($urandom_range(0, 15));
      2:       return corners[$urandom_range(0, 4)];
      default: return -32'($urandom_range(1, 300));
    endcase
  endfunction

  initial begin
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF; corners[4] = 32'h7FFF_FFFF;
    RST_N = 1'b0; Start = 1'b0; Signed_F = 1'b0; HI_We = 1'b0; LO_We = 1'b0;
    MultA = '0; MultB = '0; WrData = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hi", {32'b0, HI}, 64'd0);
    check("reset_lo", {32'b0, LO}, 64'd0);
    check("reset_busy", {63'b0, Busy}, 64'd0);
    check("reset_done", {63'b0, Done}, 64'd0);
    check("reset_state", {62'b0, dbg_state}, 64'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // directed corners
    run_mult(1'b0, 32'd3, 32'd5, 0, 0, 1'b0);
    check("multu_3x5_lo", {32'b0, LO}, 64'h0000_000F);
    run_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_mult(1'b1, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0);
    check("mult_m2x3", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);
    check("mult_min2", {HI, LO}, 64'h4000_0000_0000_0000);
    run_mult(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("mult_m1m1", {HI, LO}, 64'h0000_0000_0000_0001);

    // MTHI / MTLO in IDLE
    write_hilo(1'b1, 1'b0, 32'hCAFE_0001);
    write_hilo(1'b0, 1'b1, 32'hCAFE_0002);
    write_hilo(1'b1, 1'b1, 32'h1234_5678);

    // hazards: MTHI and a second Start while busy, Start with MTLO in IDLE
    run_mult(1'b0, 32'h0001_0003, 32'h8000_0003, 5, 10, 1'b0);
    run_mult(1'b1, 32'hFFFF_0000, 32'hC000_0001, 0, 0, 1'b1);

    // asynchronous reset mid-run, then the same multiply from clean state
    reset_mid_run(16);
    run_mult(1'b0, 32'd7, 32'd9, 0, 0, 1'b0);
    check("multu_7x9_lo", {32'b0, LO}, 64'd63);

    // multiplier of zero (short latency when early exit is built in)
    run_mult(1'b0, 32'h0000_1234, 32'h0, 0, 0, 1'b0);

    // randomized
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0)
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
      run_mult(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
